health_alarm_monitor: RTL



---
 rtl/health_alarm_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/health_alarm_monitor.sv
// Multi-channel vital-sign alarm monitor: persistence-filtered alarms, ack/recover exit, saturating episode counters.
// Optional macro HEALTH_MON_HYST_EN narrows the recovery band by HYST on each side.
module health_alarm_ch #(
  parameter int DATA_W  = 8,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8,
  parameter int HYST    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              ack,
  input  logic              clr,
  output logic              alarm,
  output logic              pending,
  output logic              pending_nxt,
  output logic [CNT_W-1:0]  cnt
);
  typedef enum logic [1:0] {NORMAL, SUSPECT, ALARM} state_t;
  localparam logic [3:0]       PER     = 4'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic [3:0]       run, run_n;
  logic             ackd, ackd_n, enter;
  logic [CNT_W-1:0] cnt_n;
  logic             abn, ok;

  assign abn = (data < lo) || (data > hi);

`ifdef HEALTH_MON_HYST_EN
  localparam logic [DATA_W:0] HYST_W = (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0] D_MAX  = {1'b0, {DATA_W{1'b1}}};
  logic [DATA_W:0] lo_w, lo_n, hi_n;
  always_comb begin
    lo_w = {1'b0, lo} + HYST_W;
    lo_n = (lo_w > D_MAX) ? D_MAX : lo_w;
    hi_n = ({1'b0, hi} < HYST_W) ? '0 : {1'b0, hi} - HYST_W;
  end
  // Inside limits but outside the narrowed band is neutral: neither abn nor ok.
  assign ok = ({1'b0, data} >= lo_n) && ({1'b0, data} <= hi_n);
`else
  assign ok = !abn;
`endif

  always_comb begin
    state_n = state;
    run_n   = run;
    ackd_n  = ackd;
    enter   = 1'b0;
    case (state)
      NORMAL: if (valid && abn) begin
        run_n = 4'd1;
        if (PER == 4'd1) enter = 1'b1;
        else state_n = SUSPECT;
      end
      SUSPECT: if (valid && abn) begin
        run_n = run + 4'd1;
        if (run_n == PER) enter = 1'b1;
      end else if (valid && ok) begin
        state_n = NORMAL;
        run_n   = '0;
      end
      ALARM: begin
        if (ack) ackd_n = 1'b1;
        if (valid && ok && (ackd || ack)) begin
          state_n = NORMAL;
          run_n   = '0;
          ackd_n  = 1'b0;
        end
      end
      default: state_n = NORMAL;
    endcase
    if (enter) begin
      state_n = ALARM;
      ackd_n  = 1'b0;
    end
    // Clear dominates a coincident increment.
    if (clr)                          cnt_n = '0;
    else if (enter && cnt != CNT_MAX) cnt_n = cnt + 1'b1;
    else                              cnt_n = cnt;
    pending_nxt = (state_n == ALARM) && !ackd_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= NORMAL;
      run     <= '0;
      ackd    <= 1'b0;
      cnt     <= '0;
      alarm   <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      run     <= run_n;
      ackd    <= ackd_n;
      cnt     <= cnt_n;
      alarm   <= (state_n == ALARM);
      pending <= pending_nxt;
    end
  end
endmodule

module health_alarm_monitor #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8,
  parameter int HYST    = 4,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sampleValid,
  input  logic [NUM_CH*DATA_W-1:0] sampleData,
  input  logic [NUM_CH*DATA_W-1:0] lowLimit,
  input  logic [NUM_CH*DATA_W-1:0] highLimit,
  input  logic [NUM_CH-1:0]       alarmAck,
  input  logic                    clearCounts,
  output logic [NUM_CH-1:0]       channelAlarm,
  output logic [NUM_CH-1:0]       alarmPending,
  output logic                    anyAlarm,
  output logic [IDX_W-1:0]        firstAlarmCh,
  output logic [NUM_CH*CNT_W-1:0] eventCount
);
  logic [NUM_CH-1:0] pend_n;
  logic [IDX_W-1:0]  first_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    health_alarm_ch #(.DATA_W(DATA_W), .PERSIST(PERSIST), .CNT_W(CNT_W), .HYST(HYST)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (sampleValid),
      .data        (sampleData[i*DATA_W +: DATA_W]),
      .lo          (lowLimit[i*DATA_W +: DATA_W]),
      .hi          (highLimit[i*DATA_W +: DATA_W]),
      .ack         (alarmAck[i]),
      .clr         (clearCounts),
      .alarm       (channelAlarm[i]),
      .pending     (alarmPending[i]),
      .pending_nxt (pend_n[i]),
      .cnt         (eventCount[i*CNT_W +: CNT_W])
    );
  end

  // Descending scan so the lowest pending index is the last write.
  always_comb begin
    first_n = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (pend_n[i]) first_n = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anyAlarm     <= 1'b0;
      firstAlarmCh <= '0;
    end else begin
      anyAlarm     <= |pend_n;
      firstAlarmCh <= first_n;
    end
  end
endmodule
